// File: rtl/inst_imm_encoder.sv
// -----------------------------------------------------------------------------
// inst_imm_encoder
//
// Purpose:
//   Builds a 32-bit RV64I instruction word from an opcode class, register and
//   funct fields and a 64-bit signed immediate. It is the inverse of the core's
//   immediate-extension logic. The debug/program-loader path uses it to
//   assemble instructions before writing them to instruction memory.
//
//   The block is a two-stage valid/ready pipeline:
//     S1: captures the request and range-checks the immediate.
//     S2: packs the fields and holds the output register.
//   When the immediate is out of range, misaligned, or the opcode is
//   unsupported, the result is a NOP (32'h0000_0013) with out_err set.
//   Two saturating counters track accepted good and bad results.
//
// Ports:
//   clk        in   clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  request accepted when in_valid && in_ready
//   in_opcode  in   inst[6:2] opcode class
//   in_rd      in   destination register field
//   in_rs1     in   source 1 register field
//   in_rs2     in   source 2 register field
//   in_funct3  in   funct3 field
//   in_funct7  in   funct7 field (R-type only)
//   in_imm     in   signed immediate (byte offsets for B/JAL)
//   out_valid  out  result valid
//   out_ready  in   downstream accepts when out_valid && out_ready
//   out_inst   out  encoded instruction
//   out_err    out  immediate/opcode error flag
//   enc_cnt    out  accepted results with out_err=0 (saturating)
//   err_cnt    out  accepted results with out_err=1 (saturating)
// -----------------------------------------------------------------------------
module inst_imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Opcode classes, inst[6:2]
  localparam logic [4:0] OP_I_ARITH = 5'b00100;
  localparam logic [4:0] OP_I_LOAD  = 5'b00000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_S       = 5'b01000;
  localparam logic [4:0] OP_B       = 5'b11000;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_R       = 5'b01100;

  localparam logic [31:0]      NOP_INST = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    CLS_I,
    CLS_S,
    CLS_B,
    CLS_U,
    CLS_J,
    CLS_R,
    CLS_BAD
  } enc_cls_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q;
  logic s2_valid_q;
  logic s1_adv;

  // S2 can take S1's contents when it is empty or is being drained this cycle.
  assign s1_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s1_adv;
  assign out_valid = s2_valid_q;

  // ---------------------------------------------------------------------------
  // S1 check logic (combinational on the incoming request)
  // ---------------------------------------------------------------------------
  // "Sign-extended from bit k" means in_imm[63:k] are all ones or all zeros.
  logic ok_11;
  logic ok_12;
  logic ok_20;
  logic ok_31;

  assign ok_11 = (&in_imm[63:11]) || !(|in_imm[63:11]);
  assign ok_12 = (&in_imm[63:12]) || !(|in_imm[63:12]);
  assign ok_20 = (&in_imm[63:20]) || !(|in_imm[63:20]);
  assign ok_31 = (&in_imm[63:31]) || !(|in_imm[63:31]);

  enc_cls_e cls_d;
  logic     err_d;

  always_comb begin
    cls_d = CLS_BAD;
    err_d = 1'b1;
    case (in_opcode)
      OP_I_ARITH, OP_I_LOAD, OP_JALR: begin
        cls_d = CLS_I;
        err_d = !ok_11;
      end
      OP_S: begin
        cls_d = CLS_S;
        err_d = !ok_11;
      end
      OP_B: begin
        cls_d = CLS_B;
        err_d = !ok_12 || in_imm[0];
      end
      OP_JAL: begin
        cls_d = CLS_J;
        err_d = !ok_20 || in_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        cls_d = CLS_U;
        err_d = !ok_31 || (|in_imm[11:0]);
      end
      OP_R: begin
        cls_d = CLS_R;
        err_d = 1'b0;
      end
      default: begin
        cls_d = CLS_BAD;
        err_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // S1 registers
  // ---------------------------------------------------------------------------
  enc_cls_e    s1_cls_q;
  logic        s1_err_q;
  logic [4:0]  s1_op_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_f7_q;
  // Only the low word is needed once the range check has been done.
  logic [31:0] s1_imm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cls_q   <= CLS_BAD;
      s1_err_q   <= 1'b0;
      s1_op_q    <= 5'd0;
      s1_rd_q    <= 5'd0;
      s1_rs1_q   <= 5'd0;
      s1_rs2_q   <= 5'd0;
      s1_f3_q    <= 3'd0;
      s1_f7_q    <= 7'd0;
      s1_imm_q   <= 32'd0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cls_q <= cls_d;
        s1_err_q <= err_d;
        s1_op_q  <= in_opcode;
        s1_rd_q  <= in_rd;
        s1_rs1_q <= in_rs1;
        s1_rs2_q <= in_rs2;
        s1_f3_q  <= in_funct3;
        s1_f7_q  <= in_funct7;
        s1_imm_q <= in_imm[31:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2 packing (combinational on S1 state)
  // ---------------------------------------------------------------------------
  logic [31:0] inst_d;
  logic [6:0]  opc7;

  assign opc7 = {s1_op_q, 2'b11};

  always_comb begin
    inst_d = NOP_INST;
    case (s1_cls_q)
      CLS_I: inst_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, opc7};
      CLS_S: inst_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                       s1_imm_q[4:0], opc7};
      CLS_B: inst_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q,
                       s1_f3_q, s1_imm_q[4:1], s1_imm_q[11], opc7};
      CLS_U: inst_d = {s1_imm_q[31:12], s1_rd_q, opc7};
      CLS_J: inst_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                       s1_imm_q[19:12], s1_rd_q, opc7};
      CLS_R: inst_d = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, opc7};
      default: inst_d = NOP_INST;
    endcase
    if (s1_err_q) begin
      inst_d = NOP_INST;
    end
  end

  // ---------------------------------------------------------------------------
  // S2 / output registers and statistics
  // ---------------------------------------------------------------------------
  logic [31:0]      out_inst_q;
  logic             out_err_q;
  logic [CNT_W-1:0] enc_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_inst_q <= 32'd0;
      out_err_q  <= 1'b0;
      enc_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      // The counters see the result leaving this cycle, before it is replaced.
      if (s2_valid_q && out_ready) begin
        if (out_err_q) begin
          if (err_cnt_q != CNT_MAX) err_cnt_q <= err_cnt_q + CNT_ONE;
        end else begin
          if (enc_cnt_q != CNT_MAX) enc_cnt_q <= enc_cnt_q + CNT_ONE;
        end
      end
      if (s1_adv) begin
        s2_valid_q <= s1_valid_q;
        // The data registers only load on a real transfer, so a bubble leaves
        // the last word visible but flagged invalid.
        if (s1_valid_q) begin
          out_inst_q <= inst_d;
          out_err_q  <= s1_err_q;
        end
      end
    end
  end

  assign out_inst = out_inst_q;
  assign out_err  = out_err_q;
  assign enc_cnt  = enc_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule
